seg_scan_monitor: RTL and testbench

SEG_SCAN_MONITOR -- requirements
Module: seg_scan_monitor

---
 rtl/seg_scan_monitor_pkg.sv | 30 +++
 rtl/seg_scan_monitor_decode.sv | 24 ++
 rtl/seg_scan_monitor.sv | 149 ++++++++++++++
 tb/tb_seg_scan_monitor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_monitor_pkg.sv
// Shared constants for the seven-segment scan monitor: active-low segment
// patterns (bit6..bit0 = g..a) and the acceptance FSM state type.
package seg_scan_monitor_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [10] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7, SEG_8, SEG_9
    };

    typedef enum logic {
        SETTLE = 1'b0,
        HOLD   = 1'b1
    } state_t;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/seg_scan_monitor_decode.sv
// Combinational seven-segment pattern decoder: flags a 0-9 digit or the
// all-off blank pattern and returns the digit value.
module seg7_decode
    import seg_scan_monitor_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       is_digit,
    output logic       is_blank,
    output logic [3:0] value
);

    always_comb begin
        is_digit = 1'b0;
        is_blank = (pattern == SEG_BLANK);
        value    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                is_digit = 1'b1;
                value    = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_monitor.sv
// Watches a multiplexed four-digit seven-segment display, debounces each scan
// slot and recovers the BCD digits, blank flags, frame and fault indications.
module seg_scan_monitor
    import seg_scan_monitor_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int DARK_CYCLES   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] led_seg,
    input  logic       a1,
    input  logic       a2,
    input  logic       a3,
    input  logic       a4,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [3:0] dig4,
    output logic [3:0] blank,
    output logic       valid,
    output logic       frame_done,
    output logic       dark,
    output logic       err_seg,
    output logic       err_multi,
    output state_t     dbg_state
);

    localparam logic [3:0]  STAB_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [15:0] DARK_MAX  = 16'(DARK_CYCLES);

    logic [10:0] in_w;
    logic [10:0] samp;
    logic [3:0]  stab_cnt;
    logic [15:0] dark_cnt;
    logic [3:0]  seen;
    state_t      state;

    logic [3:0]  anode_low;
    logic        is_digit;
    logic        is_blank;
    logic [3:0]  value;
    logic        accept;
    logic [3:0]  cap_mask;
    logic        bad_seg;
    logic        multi;
    logic [3:0]  seen_upd;

    assign in_w      = {a1, a2, a3, a4, led_seg};
    // bit3 = a1 = digit 1, matching the blank[] ordering
    assign anode_low = ~samp[10:7];
    assign dark      = (dark_cnt == DARK_MAX);
    assign dbg_state = state;

    seg7_decode u_decode (
        .pattern  (samp[6:0]),
        .is_digit (is_digit),
        .is_blank (is_blank),
        .value    (value)
    );

    assign accept = (state == SETTLE) && (in_w == samp) && (stab_cnt == STAB_LAST);

    always_comb begin
        cap_mask = 4'd0;
        bad_seg  = 1'b0;
        multi    = 1'b0;
        if (accept) begin
            if (is_one_hot(anode_low)) begin
                if (is_digit || is_blank) begin
                    cap_mask = anode_low;
                end else begin
                    bad_seg = 1'b1;
                end
            end else if (anode_low != 4'd0) begin
                multi = 1'b1;
            end
        end
        seen_upd = seen | cap_mask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp       <= 11'h7FF;
            stab_cnt   <= 4'd0;
            state      <= SETTLE;
            dark_cnt   <= 16'd0;
            seen       <= 4'd0;
            dig1       <= 4'd0;
            dig2       <= 4'd0;
            dig3       <= 4'd0;
            dig4       <= 4'd0;
            blank      <= 4'hF;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            err_seg    <= 1'b0;
            err_multi  <= 1'b0;
        end else begin
            samp       <= in_w;
            frame_done <= 1'b0;
            err_seg    <= bad_seg;
            err_multi  <= multi;

            if (in_w != samp) begin
                state    <= SETTLE;
                stab_cnt <= 4'd0;
            end else if (state == SETTLE) begin
                if (accept) begin
                    state <= HOLD;
                end else begin
                    stab_cnt <= stab_cnt + 4'd1;
                end
            end

            // A blank capture keeps the last digit value, only the flag moves
            if (cap_mask[3]) begin
                blank[3] <= is_blank;
                if (is_digit) dig1 <= value;
            end
            if (cap_mask[2]) begin
                blank[2] <= is_blank;
                if (is_digit) dig2 <= value;
            end
            if (cap_mask[1]) begin
                blank[1] <= is_blank;
                if (is_digit) dig3 <= value;
            end
            if (cap_mask[0]) begin
                blank[0] <= is_blank;
                if (is_digit) dig4 <= value;
            end

            if (seen_upd == 4'hF) begin
                frame_done <= 1'b1;
                seen       <= 4'd0;
                valid      <= 1'b1;
            end else begin
                seen <= seen_upd;
            end

            if (samp[10:7] == 4'hF) begin
                if (dark_cnt != DARK_MAX) dark_cnt <= dark_cnt + 16'd1;
            end else begin
                dark_cnt <= 16'd0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Directed and randomized scan sequences for seg_scan_monitor, compared every
// clock against a step-level model of the display contents.
module tb_seg_scan_monitor;
    import seg_scan_monitor_pkg::*;

    localparam int STABLE = 4;
    localparam int DARK   = 1024;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] led_seg;
    logic       a1, a2, a3, a4;
    logic [3:0] dig1, dig2, dig3, dig4, blank;
    logic       valid, frame_done, dark, err_seg, err_multi;
    state_t     dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference display model, digit positions 1..4 stored at index 0..3
    logic [6:0]  seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [3:0]  m_dig [4];
    logic [3:0]  m_blank;
    logic [3:0]  m_seen;
    logic        m_valid;
    int          m_dark_cnt;
    logic        m_s_high;
    logic [10:0] prev_in;

    always #5 clk = ~clk;

    seg_scan_monitor #(.STABLE_CYCLES(STABLE), .DARK_CYCLES(DARK)) dut (
        .clk        (clk),
        .rst        (rst),
        .led_seg    (led_seg),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .a4         (a4),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .dig4       (dig4),
        .blank      (blank),
        .valid      (valid),
        .frame_done (frame_done),
        .dark       (dark),
        .err_seg    (err_seg),
        .err_multi  (err_multi),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_all(input logic fd, input logic es, input logic em, input logic hold);
        check("dig1", 16'(dig1), 16'(m_dig[0]));
        check("dig2", 16'(dig2), 16'(m_dig[1]));
        check("dig3", 16'(dig3), 16'(m_dig[2]));
        check("dig4", 16'(dig4), 16'(m_dig[3]));
        check("blank", 16'(blank), 16'(m_blank));
        check("valid", 16'(valid), 16'(m_valid));
        check("frame_done", 16'(frame_done), 16'(fd));
        check("err_seg", 16'(err_seg), 16'(es));
        check("err_multi", 16'(err_multi), 16'(em));
        check("dark", 16'(dark), 16'(m_dark_cnt == DARK));
        check("state_hold", 16'(dbg_state == HOLD), 16'(hold));
    endtask

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one = 4'b1000;
        return ~(one >> (d - 1));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) m_dig[k] = 4'd0;
        m_blank    = 4'hF;
        m_seen     = 4'd0;
        m_valid    = 1'b0;
        m_dark_cnt = 0;
        m_s_high   = 1'b1;
        prev_in    = 11'h7FF;
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Holds one input value for n clocks; the value must differ from the previous one.
    task automatic run_step(input logic [3:0] an, input logic [6:0] seg, input int n);
        logic fd, es, em;
        int   idx, nlow, d;
        {a1, a2, a3, a4} = an;
        led_seg = seg;
        prev_in = {an, seg};
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            fd = 1'b0; es = 1'b0; em = 1'b0;
            if (i == STABLE) begin
                nlow = 0; d = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!an[4-k]) begin nlow++; d = k; end
                end
                if (nlow == 1) begin
                    idx = -1;
                    for (int j = 0; j < 10; j++) if (seg == seg_ref[j]) idx = j;
                    if (idx >= 0) begin
                        m_dig[d-1] = 4'(idx); m_blank[4-d] = 1'b0; m_seen[d-1] = 1'b1;
                    end else if (seg == 7'h7F) begin
                        m_blank[4-d] = 1'b1; m_seen[d-1] = 1'b1;
                    end else begin
                        es = 1'b1;
                    end
                    if (m_seen == 4'hF) begin
                        fd = 1'b1; m_seen = 4'd0; m_valid = 1'b1;
                    end
                end else if (nlow > 1) begin
                    em = 1'b1;
                end
            end
            m_dark_cnt = m_s_high ? ((m_dark_cnt < DARK) ? m_dark_cnt + 1 : DARK) : 0;
            m_s_high   = (an == 4'hF);
            check_all(fd, es, em, i >= STABLE);
        end
    endtask

    task automatic scan(input logic [6:0] s1, input logic [6:0] s2,
                        input logic [6:0] s3, input logic [6:0] s4, input int n);
        run_step(an_of(1), s1, n);
        run_step(an_of(2), s2, n);
        run_step(an_of(3), s3, n);
        run_step(an_of(4), s4, n);
    endtask

    initial begin
        logic [3:0] an;
        logic [6:0] seg;
        int         sel;

        {a1, a2, a3, a4} = 4'hF;
        led_seg = 7'h7F;
        do_reset();

        // "1234" scanned three times
        for (int f = 0; f < 3; f++) scan(7'h79, 7'h24, 7'h30, 7'h19, 8);

        // Digit 2 boundary: STABLE clocks are too few, STABLE+1 captures
        run_step(an_of(2), 7'h12, 8);
        run_step(an_of(2), 7'h24, STABLE);
        run_step(an_of(2), 7'h30, 2);
        run_step(an_of(2), 7'h24, 8);

        // Dark detection and recovery
        run_step(4'hF, 7'h7F, DARK + 76);
        run_step(an_of(3), 7'h7F, 1);
        run_step(4'hF, 7'h7F, 4);

        // Two anodes at once, then an undecodable pattern on digit 1
        run_step(4'b0110, 7'h12, 6);
        run_step(an_of(1), 7'h7E, 8);

        // "0000" alternating with fully blanked frames
        for (int f = 0; f < 2; f++) begin
            scan(7'h40, 7'h40, 7'h40, 7'h40, 6);
            scan(7'h7F, 7'h7F, 7'h7F, 7'h7F, 6);
        end

        // "9999", then reset part way into the next scan
        scan(7'h10, 7'h10, 7'h10, 7'h10, 7);
        run_step(an_of(1), 7'h79, 2);
        do_reset();
        run_step(an_of(1), 7'h79, 8);

        // Randomized scan traffic
        for (int r = 0; r < 300; r++) begin
            do begin
                sel = $urandom_range(0, 9);
                if (sel < 7)       an = an_of($urandom_range(1, 4));
                else if (sel == 7) an = 4'hF;
                else               an = 4'($urandom_range(0, 15));
                sel = $urandom_range(0, 19);
                if (sel < 12)      seg = seg_ref[$urandom_range(0, 9)];
                else if (sel < 15) seg = 7'h7F;
                else               seg = 7'($urandom_range(0, 127));
            end while ({an, seg} == prev_in);
            run_step(an, seg, $urandom_range(1, 9));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog timeout");
    end

endmodule
